// File: rtl/w5300_pkg.sv
// ============================================================================
// w5300_pkg : shared W5300 field positions, FSM encoding and timing defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package w5300_pkg;

  localparam int CADDR_INVALID_BIT = 11;
  localparam int CADDR_READ_BIT    = 10;
  localparam int CADDR_ADDR_MSB    = 9;

  localparam int unsigned DEF_CLK_FREQ   = 100;
  localparam int unsigned DEF_T_SETUP    = 1;
  localparam int unsigned DEF_T_STROBE   = 7;
  localparam int unsigned DEF_T_HOLD     = 1;
  localparam int unsigned DEF_T_RECOVER  = 2;
  localparam int unsigned DEF_RST_LOW_US  = 5;
  localparam int unsigned DEF_RST_WAIT_US = 10000;

  localparam logic [9:0]  W5300_IDR_ADDR = 10'h0FE;
  localparam logic [15:0] W5300_ID       = 16'h5300;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    S_RST_LOW  = 3'd0,
    S_RST_WAIT = 3'd1,
    S_IDLE     = 3'd2,
    S_SETUP    = 3'd3,
    S_STROBE   = 3'd4,
    S_HOLD     = 3'd5,
    S_RECOVER  = 3'd6
  } state_e;

  // A state lasting n cycles starts its down-counter at n-1 and leaves at 0.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/w5300_int_sync.sv
// ============================================================================
// w5300_int_sync : two-flop synchroniser for the active-low W5300 INTn pin
// Rev 1.0
// ============================================================================
`default_nettype none

module w5300_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n_i,
  output logic sync_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_n_i;
      sync_q <= meta_q;
    end
  end

  assign sync_n_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/w5300_parallel_if.sv
// ============================================================================
// w5300_parallel_if : W5300 boot sequencer and 16-bit direct-address bus master
// Optional macro W5300_FAST_BOOT_EN shortens the boot sequence to 8/16 cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module w5300_parallel_if
  import w5300_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
  parameter int unsigned T_SETUP     = DEF_T_SETUP,
  parameter int unsigned T_STROBE    = DEF_T_STROBE,
  parameter int unsigned T_HOLD      = DEF_T_HOLD,
  parameter int unsigned T_RECOVER   = DEF_T_RECOVER,
  parameter int unsigned RST_LOW_US  = DEF_RST_LOW_US,
  parameter int unsigned RST_WAIT_US = DEF_RST_WAIT_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] caddr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        op_status,
  output logic        int_sync_n,
  input  logic        int_n,
  output logic        w5300_rst_n,
  output logic [9:0]  w5300_addr,
  output logic [15:0] w5300_data_o,
  input  logic [15:0] w5300_data_i,
  output logic        w5300_data_oe,
  output logic        w5300_cs_n,
  output logic        w5300_rd_n,
  output logic        w5300_wr_n
);

`ifdef W5300_FAST_BOOT_EN
  localparam int unsigned RST_LOW_CYC  = 8;
  localparam int unsigned RST_WAIT_CYC = 16;
`else
  localparam int unsigned RST_LOW_CYC  = RST_LOW_US * CLK_FREQ;
  localparam int unsigned RST_WAIT_CYC = RST_WAIT_US * CLK_FREQ;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               read_q;
  logic               read_d;
  logic               bus_d;

  logic [15:0] rd_data_q;
  logic        op_status_q;
  logic        rst_n_q;
  logic [9:0]  addr_q;
  logic [15:0] data_o_q;
  logic        data_oe_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    accept  = 1'b0;
    case (state_q)
      S_RST_LOW: if (cnt_q == '0) begin
        state_d = S_RST_WAIT;
        cnt_d   = cyc_load(RST_WAIT_CYC);
      end
      S_RST_WAIT: if (cnt_q == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (!caddr[CADDR_INVALID_BIT]) begin
          state_d = S_SETUP;
          cnt_d   = cyc_load(T_SETUP);
          accept  = 1'b1;
        end
      end
      S_SETUP: if (cnt_q == '0) begin
        state_d = S_STROBE;
        cnt_d   = cyc_load(T_STROBE);
      end
      S_STROBE: if (cnt_q == '0) begin
        state_d = S_HOLD;
        cnt_d   = cyc_load(T_HOLD);
      end
      S_HOLD: if (cnt_q == '0) begin
        state_d = S_RECOVER;
        cnt_d   = cyc_load(T_RECOVER);
      end
      S_RECOVER: if (cnt_q == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_RST_LOW;
        cnt_d   = cyc_load(RST_LOW_CYC);
      end
    endcase
  end

  // Pin registers are loaded from the next state so every output is a flop
  // that changes on the same edge as the state it belongs to.
  assign read_d = accept ? caddr[CADDR_READ_BIT] : read_q;
  assign bus_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_LOW;
      cnt_q       <= cyc_load(RST_LOW_CYC);
      read_q      <= 1'b0;
      rd_data_q   <= '0;
      op_status_q <= 1'b0;
      rst_n_q     <= 1'b0;
      addr_q      <= '0;
      data_o_q    <= '0;
      data_oe_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      read_q  <= read_d;
      if (accept) begin
        addr_q <= caddr[CADDR_ADDR_MSB:0];
        if (!caddr[CADDR_READ_BIT]) data_o_q <= wr_data;
      end
      if ((state_q == S_STROBE) && (cnt_q == '0) && read_q) rd_data_q <= w5300_data_i;
      op_status_q <= ((state_d == S_RST_WAIT) || (state_d == S_RECOVER)) && (cnt_d == '0);
      rst_n_q     <= (state_d != S_RST_LOW);
      cs_n_q      <= !bus_d;
      data_oe_q   <= bus_d && !read_d;
      rd_n_q      <= !((state_d == S_STROBE) && read_d);
      wr_n_q      <= !((state_d == S_STROBE) && !read_d);
    end
  end

  w5300_int_sync u_int_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_n_i (int_n),
    .sync_n_o  (int_sync_n)
  );

  assign rd_data       = rd_data_q;
  assign op_status     = op_status_q;
  assign w5300_rst_n   = rst_n_q;
  assign w5300_addr    = addr_q;
  assign w5300_data_o  = data_o_q;
  assign w5300_data_oe = data_oe_q;
  assign w5300_cs_n    = cs_n_q;
  assign w5300_rd_n    = rd_n_q;
  assign w5300_wr_n    = wr_n_q;

endmodule

`default_nettype wire

// File: tb/tb_w5300_parallel_if.sv
// ============================================================================
// tb_w5300_parallel_if : directed bench for the W5300 bus master and boot FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_w5300_parallel_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] caddr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        op_status;
  logic        int_sync_n;
  logic        int_n;
  logic        w5300_rst_n;
  logic [9:0]  w5300_addr;
  logic [15:0] w5300_data_o;
  logic [15:0] w5300_data_i;
  logic        w5300_data_oe;
  logic        w5300_cs_n;
  logic        w5300_rd_n;
  logic        w5300_wr_n;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Chip model: ID register contents only while RD_n is low, junk otherwise.
  assign w5300_data_i = (w5300_rd_n === 1'b0) ? 16'h5300 : 16'hDEAD;

  w5300_parallel_if #(
    .CLK_FREQ    (1),
    .RST_LOW_US  (8),
    .RST_WAIT_US (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .caddr         (caddr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .op_status     (op_status),
    .int_sync_n    (int_sync_n),
    .int_n         (int_n),
    .w5300_rst_n   (w5300_rst_n),
    .w5300_addr    (w5300_addr),
    .w5300_data_o  (w5300_data_o),
    .w5300_data_i  (w5300_data_i),
    .w5300_data_oe (w5300_data_oe),
    .w5300_cs_n    (w5300_cs_n),
    .w5300_rd_n    (w5300_rd_n),
    .w5300_wr_n    (w5300_wr_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Releases rst_n at the current falling edge and times the boot phases.
  task automatic do_boot(input string tag);
    int n;
    int m;
    int busy;
    n = 0; m = 0; busy = 0;
    rst_n = 1'b1;
    while (w5300_rst_n === 1'b0 && n < 100) begin
      if (w5300_cs_n !== 1'b1 || op_status !== 1'b0) busy++;
      n++;
      @(negedge clk);
    end
    check({tag, "_rst_low_cycles"}, n, 8);
    while (op_status !== 1'b1 && m < 100) begin
      if (w5300_cs_n !== 1'b1 || w5300_rst_n !== 1'b1) busy++;
      m++;
      @(negedge clk);
    end
    check({tag, "_rst_wait_cycles"}, m, 15);
    check({tag, "_rst_n_at_done"}, w5300_rst_n, 1);
    check({tag, "_no_bus_activity"}, busy, 0);
  endtask

  // Follows one access from now until its op_status pulse.
  task automatic run_access(input string tag, input bit is_read, input logic [9:0] exp_addr,
                            input logic [15:0] exp_wdata, input int exp_wait, input bit scramble);
    int n;
    int t;
    int cs_lo;
    int rd_lo;
    int wr_lo;
    int bad;
    int op_at;
    n = 0; t = 0; cs_lo = 0; rd_lo = 0; wr_lo = 0; bad = 0; op_at = -1;
    while (w5300_cs_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_wait"}, n, exp_wait);
    while (t < 40) begin
      if (w5300_cs_n === 1'b0) begin
        cs_lo++;
        if (w5300_addr !== exp_addr) bad++;
        if (w5300_data_oe !== !is_read) bad++;
        if (!is_read && w5300_data_o !== exp_wdata) bad++;
      end else if (w5300_data_oe !== 1'b0) begin
        bad++;
      end
      if (w5300_rd_n === 1'b0) rd_lo++;
      if (w5300_wr_n === 1'b0) wr_lo++;
      if (op_status === 1'b1) begin
        op_at = t;
        break;
      end
      if (t == 1 && scramble) begin
        caddr   = 12'h8AA;
        wr_data = 16'hBEEF;
      end
      @(negedge clk);
      t++;
    end
    check({tag, "_cs_low_cycles"}, cs_lo, 9);
    check({tag, "_rd_low_cycles"}, rd_lo, is_read ? 7 : 0);
    check({tag, "_wr_low_cycles"}, wr_lo, is_read ? 0 : 7);
    check({tag, "_op_latency"}, op_at, 10);
    check({tag, "_addr_data_oe_errs"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [6:1] int_exp;
    rst_n   = 1'b0;
    caddr   = 12'h800;
    wr_data = 16'h0000;
    int_n   = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_w5300_rst_n", w5300_rst_n, 0);
    check("rst_cs_n", w5300_cs_n, 1);
    check("rst_rd_n", w5300_rd_n, 1);
    check("rst_wr_n", w5300_wr_n, 1);
    check("rst_addr", w5300_addr, 0);
    check("rst_data_o", w5300_data_o, 0);
    check("rst_data_oe", w5300_data_oe, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_op_status", op_status, 0);
    check("rst_int_sync_n", int_sync_n, 1);

    // Read command held through boot must only start after boot completes.
    caddr = 12'h4FE;
    do_boot("boot");
    run_access("rd", 1'b1, 10'h0FE, 16'h0000, 2, 1'b0);
    check("rd_data_at_op", rd_data, 16'h5300);
    caddr = 12'h800;
    @(negedge clk);
    check("op_pulse_one_cycle", op_status, 0);
    check("idle_cs_n", w5300_cs_n, 1);

    // Write with inputs changed mid-access; latched values must win.
    caddr   = 12'h202;
    wr_data = 16'h0002;
    run_access("wr", 1'b0, 10'h202, 16'h0002, 1, 1'b1);
    check("wr_keeps_rd_data", rd_data, 16'h5300);

    // Level-sensitive re-issue: same command held across two completions.
    caddr   = 12'h200;
    wr_data = 16'h1234;
    run_access("b2b1", 1'b0, 10'h200, 16'h1234, 2, 1'b0);
    run_access("b2b2", 1'b0, 10'h200, 16'h1234, 2, 1'b0);
    caddr = 12'h800;

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    caddr   = 12'h2AB;
    wr_data = 16'hA5A5;
    n = 0;
    while (w5300_wr_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_strobe", n < 20, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    caddr = 12'h4FE;
    #1;
    check("mid_reset_wr_n", w5300_wr_n, 1);
    check("mid_reset_data_oe", w5300_data_oe, 0);
    check("mid_reset_w5300_rst_n", w5300_rst_n, 0);
    check("mid_reset_cs_n", w5300_cs_n, 1);
    check("mid_reset_rd_data", rd_data, 0);
    @(negedge clk);
    do_boot("reboot");
    run_access("rd2", 1'b1, 10'h0FE, 16'h0000, 2, 1'b0);
    check("rd2_data_at_op", rd_data, 16'h5300);
    caddr = 12'h800;

    // INTn low for three edges appears two cycles later for three cycles.
    @(negedge clk);
    check("int_idle_high", int_sync_n, 1);
    int_n   = 1'b0;
    int_exp = 6'b110001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("int_sync_n_s%0d", i), int_sync_n, int_exp[i]);
      if (i == 3) int_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/w5300_parallel_if.md
Name: w5300_parallel_if

Overview:
- Downstream stage of the W5300 UDP configuration/communication FSM; the only block that touches the W5300 pins.
- Converts single register commands (caddr/wr_data) into W5300 direct-address, 16-bit parallel bus cycles with programmable timing.
- Owns the W5300 hardware-reset/boot sequence and returns read data plus a one-cycle completion pulse (op_status).
- Synchronises the W5300 interrupt pin for upstream use.

Parameters:
- CLK_FREQ, 100, clk frequency in MHz.
- T_SETUP, 1, cycles with CS low and address/data stable before the strobe (≥1).
- T_STROBE, 7, cycles RD_n/WR_n held low (≥1).
- T_HOLD, 1, cycles CS low, address/data held after the strobe rises (≥1).
- T_RECOVER, 2, cycles CS high before the next access (≥1).
- RST_LOW_US, 5, W5300 reset pulse width in µs.
- RST_WAIT_US, 10000, wait after reset release (PLL lock) in µs.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- caddr  in  12  command: [11]=1 no request, [10]=1 read / 0 write, [9:0] W5300 address
- wr_data  in  16  write data, sampled when a command is accepted
- rd_data  out  16  read result, valid from op_status onward until the next read completes
- op_status  out  1  one-cycle pulse: boot complete, or access complete
- int_sync_n  out  1  int_n after a 2-FF synchroniser
- int_n  in  1  W5300 INTn pin (asynchronous)
- w5300_rst_n  out  1  W5300 RESETn
- w5300_addr  out  10  W5300 ADDR[9:0]
- w5300_data_o  out  16  data bus output
- w5300_data_i  in  16  data bus input
- w5300_data_oe  out  1  data bus output enable; the top level instantiates the tristate buffer
- w5300_cs_n, w5300_rd_n, w5300_wr_n  out  1 each  bus strobes

Behaviour:
Reset values:
- w5300_rst_n=0; cs_n=rd_n=wr_n=1; addr=0; data_o=0; data_oe=0; rd_data=0; op_status=0; int_sync_n=1.
- All outputs are registered.

States: S_RST_LOW, S_RST_WAIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER.
- A single down-counter (24 bits) times every state.
- S_RST_LOW: w5300_rst_n=0 for RST_LOW_US*CLK_FREQ cycles, then → S_RST_WAIT.
- S_RST_WAIT: w5300_rst_n=1 for RST_WAIT_US*CLK_FREQ cycles. op_status=1 in the last cycle, then → S_IDLE.
- Commands arriving during boot are ignored, not queued.
- S_IDLE: if caddr[11]==0, latch caddr[10:0] and wr_data, drive addr, → S_SETUP. Otherwise stay in S_IDLE.
- S_SETUP (T_SETUP cycles): cs_n=0.
  - Write: data_oe=1, data_o=latched wr_data.
  - Read: data_oe=0.
- S_STROBE (T_STROBE cycles): rd_n=0 (read) or wr_n=0 (write).
  - Read: rd_data loads w5300_data_i at the clock edge ending the last strobe cycle.
- S_HOLD (T_HOLD cycles): strobes=1; cs_n, addr and data_oe unchanged.
- S_RECOVER (T_RECOVER cycles): cs_n=1, data_oe=0. op_status=1 in the final cycle, then → S_IDLE.

Latency and command rules:
- If the accept edge is cycle 0, op_status is high in cycle T_SETUP+T_STROBE+T_HOLD+T_RECOVER (11 with defaults).
- Commands are level-sensitive. If caddr[11] is still 0 in the S_IDLE cycle after op_status, the command is issued again.
- Upstream must change or invalidate caddr in the op_status cycle.
- caddr/wr_data changes during an access have no effect, because the inputs are latched.

Boundaries:
- rd_data is unchanged by writes.
- caddr[0] is driven as given; no alignment check.
- rst_n assertion mid-access: strobes go high and data_oe goes 0 immediately (asynchronously); the full boot sequence restarts.

Optional Feature:
- Macro W5300_FAST_BOOT_EN.
- Defined: S_RST_LOW lasts 8 cycles and S_RST_WAIT lasts 16 cycles, for simulation.
- Undefined: durations come from RST_LOW_US/RST_WAIT_US × CLK_FREQ.
- Bus timing is identical in both cases.

Decomposition:
- Package w5300_pkg:
  - caddr field positions (CADDR_INVALID_BIT=11, CADDR_READ_BIT=10, CADDR_ADDR_MSB=9);
  - state encodings;
  - default timing constants;
  - IDR address 10'h0FE and expected ID 16'h5300 (shared with the upstream FSM).
- Sub-module w5300_int_sync: 2-FF synchroniser, reset value 1.

Test Plan:
- Boot with W5300_FAST_BOOT_EN: release rst_n → w5300_rst_n low 8 cycles, high 16 cycles, op_status pulse in the last wait cycle. caddr=12'h4FE held during boot → no cs_n activity.
- Read: caddr=12'h4FE, bench model drives 16'h5300 while rd_n=0 → cs_n low 9 cycles, rd_n low 7 cycles, rd_data=16'h5300 at op_status, op_status 11 cycles after accept.
- Write: caddr=12'h202, wr_data=16'h0002 → addr=10'h202, data_oe=1 and data_o=16'h0002 for all cs_n-low cycles, wr_n low exactly 7 cycles, rd_data unchanged.
- Back-to-back: caddr held at 12'h200 for two completions → second access starts in the S_IDLE cycle after op_status; cs_n high ≥2 cycles between accesses.
- Reset mid-access: assert rst_n during S_STROBE of a write → wr_n=1, data_oe=0, w5300_rst_n=0 immediately; a full boot precedes the next access.
- Interrupt: int_n pulses low for 3 cycles → int_sync_n low for 3 cycles, delayed 2 cycles; int_sync_n=1 after reset.
